// File: rtl/game_pkg.sv
// Shared types and default parameters for the game sequencer.
package game_pkg;

  localparam int unsigned STATE_W           = 3;
  localparam int unsigned LIVES_W           = 3;
  localparam int unsigned CNT_W             = 8;
  localparam int unsigned SCORE_W_DEF       = 8;
  localparam int unsigned LIVES_INIT_DEF    = 3;
  localparam int unsigned WIN_SCORE_DEF     = 10;
  localparam int unsigned FREEZE_FRAMES_DEF = 30;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    FREEZE = 3'd2,
    OVER   = 3'd3,
    WIN    = 3'd4
  } game_state_t;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter stepped by a per-frame strobe; stops at zero.
module frame_down_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q;

  // Load wins over a coincident decrement.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= (count_d == '0);
    end
  end

  assign count_o = count_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/game_state_fsm.sv
// Game sequencer: phase FSM plus lives/score bookkeeping and object
// freeze/respawn control driven by hit, reward, frame and start inputs.
module game_state_fsm
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = LIVES_INIT_DEF,
  parameter int unsigned SCORE_W       = SCORE_W_DEF,
  parameter int unsigned WIN_SCORE     = WIN_SCORE_DEF,
  parameter int unsigned FREEZE_FRAMES = FREEZE_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               hitPulse,
  input  logic               rewardPulse,
  output logic [STATE_W-1:0] gameState,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic               freezeObjects,
  output logic               respawnPulse,
  output logic               gameOver,
  output logic               gameWin
);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               freeze_q, freeze_d;
  logic               respawn_q, respawn_d;
  logic               over_q, over_d;
  logic               win_q, win_d;
  logic               key_q;
  logic               start_evt;

  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_value;
  logic               cnt_zero;
  logic               cnt_last;

  assign start_evt = startKey && !key_q;
  assign cnt_dec   = startOfFrame && (state_q == FREEZE);
  // A zero count in FREEZE is unreachable; treating it as last avoids a lockup.
  assign cnt_last  = (cnt_value == CNT_W'(1)) || cnt_zero;

  frame_down_counter u_freeze_cnt (
    .clk        (clk),
    .resetN     (resetN),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(FREEZE_FRAMES)),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    respawn_d = 1'b0;
    cnt_load  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_evt) begin
          state_d   = PLAY;
          lives_d   = LIVES_W'(LIVES_INIT);
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      PLAY: begin
        // A hit masks a reward arriving in the same cycle.
        if (hitPulse) begin
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d  = lives_q - LIVES_W'(1);
            state_d  = FREEZE;
            cnt_load = 1'b1;
          end
        end else if (rewardPulse) begin
          if (score_q != '1) begin
            score_d = score_q + SCORE_W'(1);
          end
          if (score_d >= SCORE_W'(WIN_SCORE)) begin
            state_d = WIN;
          end
        end
      end
      FREEZE: begin
        if (startOfFrame && cnt_last) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
        end
      end
      OVER, WIN: begin
        if (start_evt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    freeze_d = (state_d != PLAY);
    over_d   = (state_d == OVER);
    win_d    = (state_d == WIN);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      lives_q   <= LIVES_W'(LIVES_INIT);
      score_q   <= '0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      over_q    <= 1'b0;
      win_q     <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
      over_q    <= over_d;
      win_q     <= win_d;
      key_q     <= startKey;
    end
  end

  assign gameState     = state_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign freezeObjects = freeze_q;
  assign respawnPulse  = respawn_q;
  assign gameOver      = over_q;
  assign gameWin       = win_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Vector table plus scoreboard bench for game_state_fsm.
module tb_game_state_fsm;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       key = 1'b0;
  logic       hit = 1'b0;
  logic       rew = 1'b0;
  logic [2:0] gameState;
  logic [2:0] lives;
  logic [7:0] score;
  logic       freezeObjects;
  logic       respawnPulse;
  logic       gameOver;
  logic       gameWin;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sof;
    logic       key;
    logic       hit;
    logic       rew;
    logic [2:0] st;
    logic [2:0] lv;
    logic [7:0] sc;
    logic       frz;
    logic       rsp;
    logic       ovr;
    logic       win;
    string      tag;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  game_state_fsm dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .startKey      (key),
    .hitPulse      (hit),
    .rewardPulse   (rew),
    .gameState     (gameState),
    .lives         (lives),
    .score         (score),
    .freezeObjects (freezeObjects),
    .respawnPulse  (respawnPulse),
    .gameOver      (gameOver),
    .gameWin       (gameWin)
  );

  // Flag outputs follow from the expected phase.
  function automatic vec_t mk(input int s, input int k, input int h, input int r,
                              input int st, input int lv, input int sc,
                              input int rsp, input string tag);
    vec_t v;
    v.sof = 1'(s);
    v.key = 1'(k);
    v.hit = 1'(h);
    v.rew = 1'(r);
    v.st  = 3'(st);
    v.lv  = 3'(lv);
    v.sc  = 8'(sc);
    v.rsp = 1'(rsp);
    v.frz = (st != 1);
    v.ovr = (st == 3);
    v.win = (st == 4);
    v.tag = tag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t e);
    chk({e.tag, ".gameState"},     32'(gameState),     32'(e.st));
    chk({e.tag, ".lives"},         32'(lives),         32'(e.lv));
    chk({e.tag, ".score"},         32'(score),         32'(e.sc));
    chk({e.tag, ".freezeObjects"}, 32'(freezeObjects), 32'(e.frz));
    chk({e.tag, ".respawnPulse"},  32'(respawnPulse),  32'(e.rsp));
    chk({e.tag, ".gameOver"},      32'(gameOver),      32'(e.ovr));
    chk({e.tag, ".gameWin"},       32'(gameWin),       32'(e.win));
  endtask

  // Drive one cycle of inputs (called just after a negedge) and queue its expectation.
  task automatic apply(input vec_t v);
    sof = v.sof;
    key = v.key;
    hit = v.hit;
    rew = v.rew;
    exp_q.push_back(v);
    @(negedge clk);
    sof = 1'b0;
    key = 1'b0;
    hit = 1'b0;
    rew = 1'b0;
  endtask

  always @(posedge clk) begin
    vec_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_outs(e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 1, "start"));
    for (int i = 0; i < 100; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, "hold_key"));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 3, i, 0, "reward"));
    tbl.push_back(mk(0, 0, 0, 1, 4, 3, 10, 0, "reward_win"));
    tbl.push_back(mk(0, 0, 0, 1, 4, 3, 10, 0, "win_reward_ignored"));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 10, 0, "win_to_idle"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 10, 0, "idle_wait"));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 1, "restart"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, "play"));
    tbl.push_back(mk(0, 0, 1, 0, 2, 2, 0, 0, "hit1"));
    tbl.push_back(mk(0, 0, 1, 1, 2, 2, 0, 0, "freeze_hit_ignored"));
    tbl.push_back(mk(0, 1, 0, 0, 2, 2, 0, 0, "freeze_start_ignored"));
    for (int i = 0; i < 29; i++) tbl.push_back(mk(1, 0, 0, 0, 2, 2, 0, 0, "freeze1_sof"));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0, 1, "freeze1_exit"));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 0, 0, "hit2"));
    for (int i = 0; i < 29; i++) tbl.push_back(mk(1, 0, 0, 0, 2, 1, 0, 0, "freeze2_sof"));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, "freeze2_exit"));
    tbl.push_back(mk(0, 0, 1, 0, 3, 0, 0, 0, "hit3_over"));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, "over_hold"));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, "over_to_idle"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, "idle_no_reload"));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 1, "restart2"));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 3, i, 0, "reward5"));
    tbl.push_back(mk(0, 0, 1, 1, 2, 2, 5, 0, "hit_and_reward"));
    for (int i = 0; i < 29; i++) tbl.push_back(mk(1, 0, 0, 0, 2, 2, 5, 0, "freeze3_sof"));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 5, 1, "freeze3_exit"));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2, 6, 0, "reward6"));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2, 7, 0, "reward7"));
    tbl.push_back(mk(0, 0, 1, 0, 2, 1, 7, 0, "hit_lv1"));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 2, 1, 7, 0, "freeze4_sof"));

    resetN = 1'b0;
    repeat (3) @(negedge clk);
    check_outs(mk(0, 0, 0, 0, 0, 3, 0, 0, "reset"));
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Asynchronous reset in the middle of a freeze.
    #2;
    resetN = 1'b0;
    #1;
    check_outs(mk(0, 0, 0, 0, 0, 3, 0, 0, "reset_mid_freeze"));
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    apply(mk(0, 1, 0, 0, 1, 3, 0, 1, "start_after_reset"));
    apply(mk(0, 0, 0, 0, 1, 3, 0, 0, "play_after_reset"));

    // Illegal encoding must fall back to IDLE on the next edge.
    force dut.state_q = game_state_t'(3'd7);
    #1;
    release dut.state_q;
    apply(mk(0, 0, 0, 0, 0, 3, 0, 0, "illegal_recover"));
    apply(mk(0, 1, 0, 0, 1, 3, 0, 1, "start_after_recover"));

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
Name: game_state_fsm

Overview:
- Top-level game sequencer for the VGA game.
- Consumes the per-frame single-hit pulse and a reward pulse from collision logic, the start-of-frame strobe, and the start key.
- Maintains lives, score and game phase, and drives object freeze/respawn controls to the object movement blocks.
- Sits between the collision controller and the object/display blocks; all outputs are registered.

Parameters:
- LIVES_INIT, 3, lives loaded on game start (1..7).
- SCORE_W, 8, score register width.
- WIN_SCORE, 10, score at which the game is won (must be < 2^SCORE_W).
- FREEZE_FRAMES, 30, frames objects stay frozen after a hit (1..255).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-clk pulse per frame.
- startKey  in  1  level, synchronous, high while pressed.
- hitPulse  in  1  one-clk pulse, at most one per frame; player lost a life.
- rewardPulse  in  1  one-clk pulse; player scored one point.
- gameState  out  3  encoded state (IDLE=0, PLAY=1, FREEZE=2, OVER=3, WIN=4).
- lives  out  3  remaining lives.
- score  out  SCORE_W  current score, binary.
- freezeObjects  out  1  high while objects must not move.
- respawnPulse  out  1  one-clk pulse; objects return to start positions.
- gameOver  out  1  high in OVER.
- gameWin  out  1  high in WIN.

Behaviour:
- Reset (async, resetN=0): state=IDLE, lives=LIVES_INIT, score=0, freezeObjects=1, respawnPulse=0, gameOver=0, gameWin=0, freeze counter=0, startKey edge register=0.
- Start detection: startKey is registered once. A start event is a rising edge (startKey=1, previous=0). Holding the key produces exactly one event.
- IDLE: freezeObjects=1. On start event, go to PLAY next cycle; load lives=LIVES_INIT and score=0; pulse respawnPulse for one clk.
- PLAY: freezeObjects=0.
  - rewardPulse: score+1, saturating at 2^SCORE_W-1. If the new score >= WIN_SCORE, go to WIN.
  - hitPulse: lives-1.
    - If lives was 1, lives becomes 0 and the state goes to OVER.
    - Otherwise go to FREEZE with the counter = FREEZE_FRAMES.
  - hitPulse and rewardPulse in the same clk: the hit is processed and the reward is discarded.
- FREEZE: freezeObjects=1. hitPulse and rewardPulse are ignored.
  - Each startOfFrame decrements the counter.
  - When startOfFrame arrives with counter==1: go to PLAY and pulse respawnPulse in the same transition cycle.
  - Minimum freeze is exactly FREEZE_FRAMES startOfFrame pulses.
- OVER: gameOver=1, freezeObjects=1. A start event goes to IDLE with no reload; the reload happens on the next start event in IDLE, so two presses are needed to restart.
- WIN: gameWin=1, freezeObjects=1. The start event behaves as in OVER.
- Latency: every input-caused state/output change is visible one clk after the input pulse. gameState, gameOver and gameWin are decoded from registered state.
- Outputs hold their values in all states except as listed above.
- A start event in PLAY or FREEZE is ignored.
- Reset mid-game returns everything to reset values immediately, with no respawnPulse.
- Illegal state encodings recover to IDLE on the next clk.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic[2:0] game_state_t {IDLE, PLAY, FREEZE, OVER, WIN};
  - localparams for default LIVES_INIT, WIN_SCORE and FREEZE_FRAMES.
- One natural sub-module: frame_down_counter (8-bit, load/decrement on startOfFrame, zero flag), reused for freeze timing.
- The FSM, lives and score registers stay in game_state_fsm.

Test Plan:
- Reset, then a startKey rising edge -> next clk gameState=1, lives=3, score=0, respawnPulse high for exactly 1 clk, freezeObjects=0. Hold startKey for 100 clk -> no further respawnPulse.
- In PLAY apply 10 rewardPulse -> score counts 1..10. After the 10th pulse, gameState=4, gameWin=1, freezeObjects=1. An 11th pulse -> score stays 10.
- In PLAY apply hitPulse -> lives=2, gameState=2. Apply 29 startOfFrame -> still FREEZE. The 30th -> gameState=1 and respawnPulse=1. A hitPulse during FREEZE -> lives unchanged.
- Three hits (each followed by a full freeze) -> lives 2, 1, 0. After the third, gameState=3 and gameOver=1. One start edge -> IDLE. A second start edge -> PLAY with lives=3, score=0.
- With score=5 in PLAY, apply hitPulse and rewardPulse in the same clk -> lives decremented, score stays 5, gameState=2.
- Deassert resetN mid-FREEZE with lives=1 and score=7 -> immediately gameState=0, lives=3, score=0, respawnPulse=0. Force an illegal state 7 -> IDLE on the next clk.
